// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side frame buffer behind the UART RX controller.
// Ports: CLK/RST (async active-low); P_DATA/data_valid/frm_err from the
// deserializer; rd_en -> rd_data/rd_valid (registered pop); empty/full/count
// occupancy; overflow + ovf_clr sticky drop flag; err_cnt + err_clr
// saturating aborted-frame counter.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  frm_err,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [7:0]            err_cnt,
    input  logic                  err_clr
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  drop;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);

    // A read at full frees a slot in the same edge, so the write may proceed.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = data_valid & (~full | rd_acc);
    assign drop   = data_valid & ~wr_acc;

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_nxt = count - (ADDR_WIDTH + 1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // A clear coinciding with an error counts that error.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_cnt <= frm_err ? 8'd1 : 8'd0;
        end else if (frm_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART RX controller.
- Captures each deserialized frame on the controller's one-cycle data_valid pulse.
- Holds frames in a small synchronous FIFO until the system side reads them.
- Keeps a sticky overflow flag and a saturating count of aborted (parity/stop error) frames.
- Runs in the UART oversampling clock domain, same clock as the RX controller.

Parameters:
DATA_WIDTH, 8, width of one received frame payload
DEPTH, 8, number of FIFO entries; power of two, >= 2
ADDR_WIDTH, 3, log2(DEPTH)

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel frame from the deserializer; sampled only when data_valid=1
data_valid  input  1  one-cycle pulse: frame complete and error-free
frm_err  input  1  one-cycle pulse: frame aborted by parity or stop error
rd_en  input  1  system read request
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse: rd_data holds a newly popped entry
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a frame was dropped because the FIFO was full
ovf_clr  input  1  clears overflow
err_cnt  output  8  saturating count of frm_err pulses
err_clr  input  1  clears err_cnt

Behaviour:
- Reset (RST=0, asynchronous): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow=0, err_cnt=0. Storage array is not reset; contents are don't-care.
- Pointers are ADDR_WIDTH bits wide and wrap DEPTH-1 -> 0. empty and full are decoded from count: empty = (count==0), full = (count==DEPTH).
- Read accept: rd_acc = rd_en & ~empty.
  - rd_data <= mem[rd_ptr] and rd_ptr++ on the same edge.
  - rd_valid=1 for exactly the following cycle.
  - rd_en while empty is ignored: rd_valid=0, rd_data holds its last value.
- Write accept: wr_acc = data_valid & (~full | rd_acc).
  - mem[wr_ptr] <= P_DATA and wr_ptr++.
  - At full with a simultaneous read, both operations occur and count stays DEPTH.
- Empty with simultaneous data_valid and rd_en: the write is accepted and the read is ignored. There is no fall-through; the entry is readable from the next cycle.
- Drop: data_valid & ~wr_acc drops the frame. overflow <= 1; pointers and count are unchanged.
- overflow clears on ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- count update: count + wr_acc - rd_acc, applied in one edge.
- Latency:
  - data_valid at edge N: empty falls and count updates after edge N.
  - rd_en at edge N+1 gives rd_valid/rd_data after edge N+1.
- err_cnt: +1 per frm_err pulse, saturating at 255.
  - err_clr forces 0.
  - err_clr and frm_err in the same cycle: result is 1.
- data_valid and frm_err asserted together: both are honoured independently. This cannot occur from the controller but must not corrupt state.
- Reset mid-operation: all queued data is discarded; state returns to reset values immediately.

Test Plan:
1. Reset, then write 0xA5, 0x3C via data_valid pulses -> count=2, empty=0. rd_en twice gives rd_data 0xA5 then 0x3C, each with a 1-cycle rd_valid; then empty=1.
2. Write 8 frames 0x01..0x08 -> full=1, count=8. A 9th write 0xFF sets overflow=1 and count stays 8. Reads return 0x01..0x08; ovf_clr then drops overflow to 0.
3. At full, pulse data_valid=0x55 and rd_en in the same cycle -> rd_data=oldest entry, count stays 8, overflow stays 0. 0x55 is read out last.
4. Empty FIFO, data_valid=0x77 with rd_en simultaneously -> rd_valid=0 that cycle, count=1. The next rd_en returns 0x77.
5. Pulse frm_err 260 times -> err_cnt saturates at 255. err_clr together with frm_err gives err_cnt=1.
6. Load 3 entries, assert RST low mid-stream -> immediately count=0, empty=1, overflow=0, err_cnt=0, rd_valid=0. Pointer wrap is checked by 20 write/read pairs returning data in order.
